// File: rtl/rng_arbiter.sv
// rng_arbiter: two-requester round-robin arbiter that hands out bytes from an
// 8-bit LFSR (x^8+x^6+x^5+x^4+1). Each grant costs STEPS LFSR shifts, and the
// shifts happen only while the owning requester keeps its request raised.
//
// Ports:
//   clk     - system clock, rising edge
//   ar      - synchronous active-low reset
//   req     - per-requester level request, held until granted
//   seed_ld - one-cycle pulse, loads seed into the LFSR (0x00 is mapped to 0x01)
//   seed    - seed value, qualified by seed_ld
//   gnt     - one-hot grant pulse, registered
//   rnd     - delivered byte, valid with gnt and held afterwards
//   busy    - high whenever the FSM is not IDLE
module rng_arbiter #(
    parameter int STEPS = 8
) (
    input  logic       clk,
    input  logic       ar,
    input  logic [1:0] req,
    input  logic       seed_ld,
    input  logic [7:0] seed,
    output logic [1:0] gnt,
    output logic [7:0] rnd,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;

    localparam logic [3:0] STEPS_L = 4'(STEPS);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] rnd_q, rnd_d;
    logic [1:0] gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [7:0] sr_shift;

    assign sr_shift = {sr_q[6:0], sr_q[7] ^ sr_q[5] ^ sr_q[4] ^ sr_q[3]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rnd_d   = rnd_q;
        gnt_d   = 2'b00;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester not granted last wins.
                    owner_d = (req == 2'b11) ? ~last_q : req[1];
                    cnt_d   = STEPS_L;
                    state_d = STEP;
                end
            end
            STEP: begin
                if (req[owner_q]) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        // gnt is registered, so it is set on the same edge
                        // that enters GRANT and is high only in GRANT.
                        state_d = GRANT;
                        rnd_d   = sr_shift;
                        gnt_d   = owner_q ? 2'b10 : 2'b01;
                    end
                end else begin
                    // Owner withdrew: abandon without shifting or granting.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reseeding wins over everything except reset, including a final
        // shift that would otherwise have produced a grant.
        if (seed_ld) begin
            sr_d    = (seed == 8'h00) ? 8'h01 : seed;
            state_d = IDLE;
            gnt_d   = 2'b00;
            rnd_d   = rnd_q;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!ar) begin
            state_q <= IDLE;
            sr_q    <= 8'h01;
            rnd_q   <= 8'h00;
            gnt_q   <= 2'b00;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rnd_q   <= rnd_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt  = gnt_q;
    assign rnd  = rnd_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
module tb_rng_arbiter;
    localparam int STEPS = 8;

    logic       clk = 1'b0;
    logic       ar = 1'b0;
    logic [1:0] req = 2'b00;
    logic       seed_ld = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [1:0] gnt;
    logic [7:0] rnd;
    logic       busy;

    rng_arbiter #(.STEPS(STEPS)) dut (
        .clk(clk), .ar(ar), .req(req), .seed_ld(seed_ld), .seed(seed),
        .gnt(gnt), .rnd(rnd), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] r;
    } exp_t;
    exp_t sb[$];

    logic [7:0] m_sr;
    logic       m_last;

    function automatic logic [7:0] lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predict the next grant for a given request pattern and queue it.
    task automatic push_exp(input logic [1:0] r);
        logic owner;
        owner = (r == 2'b11) ? ~m_last : r[1];
        for (int i = 0; i < STEPS; i++) m_sr = lfsr(m_sr);
        m_last = owner;
        sb.push_back({(owner ? 2'b10 : 2'b01), m_sr});
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == 2'b00 && n < 200);
    endtask

    task automatic get_grant(input string tag);
        int   n;
        exp_t e;
        wait_gnt(n);
        chk({tag, " latency"}, n, STEPS + 1);
        chk({tag, " sb nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " gnt"}, gnt, e.g);
            chk({tag, " rnd"}, rnd, e.r);
        end
        tick();
        chk({tag, " gnt pulse width"}, gnt, 2'b00);
        chk({tag, " idle after grant"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        ar = 1'b0;
        req = 2'b00;
        seed_ld = 1'b0;
        tick();
        tick();
        ar = 1'b1;
        m_sr = 8'h01;
        m_last = 1'b1;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset values
        ar = 1'b0;
        tick();
        tick();
        chk("reset gnt", gnt, 2'b00);
        chk("reset rnd", rnd, 8'h00);
        chk("reset busy", busy, 1'b0);
        do_reset();

        // Single requester 0, held: two back-to-back grants
        req = 2'b01;
        push_exp(2'b01);
        get_grant("r0 first");
        chk("r0 first const", rnd, 8'h1C);
        push_exp(2'b01);
        get_grant("r0 second");
        chk("r0 second const", rnd, 8'h4B);
        req = 2'b00;

        // Both requesting: alternate 01,10,01, first tie goes to req[0]
        do_reset();
        req = 2'b11;
        push_exp(2'b11);
        push_exp(2'b11);
        push_exp(2'b11);
        get_grant("rr0");
        chk("rr0 const", rnd, 8'h1C);
        get_grant("rr1");
        chk("rr1 const", rnd, 8'h4B);
        get_grant("rr2");
        req = 2'b00;

        // Lone requester 1
        do_reset();
        req = 2'b10;
        push_exp(2'b10);
        get_grant("r1 only");
        req = 2'b00;

        // Abort after 3 shifts, then resume from sr=0x08
        do_reset();
        req = 2'b01;
        tick(); tick(); tick(); tick();
        chk("abort busy during step", busy, 1'b1);
        for (int i = 0; i < 3; i++) m_sr = lfsr(m_sr);
        req = 2'b00;
        tick();
        chk("abort busy", busy, 1'b0);
        chk("abort gnt", gnt, 2'b00);
        chk("abort rnd", rnd, 8'h00);
        tick();
        chk("abort no late gnt", gnt, 2'b00);
        req = 2'b01;
        push_exp(2'b01);
        get_grant("resume");
        chk("resume const", rnd, 8'hE2);
        req = 2'b00;

        // seed_ld with seed 0 during STEP
        do_reset();
        req = 2'b01;
        tick(); tick(); tick(); tick();
        seed_ld = 1'b1;
        seed = 8'h00;
        req = 2'b00;
        tick();
        seed_ld = 1'b0;
        m_sr = 8'h01;
        chk("seed0 busy", busy, 1'b0);
        chk("seed0 gnt", gnt, 2'b00);
        tick();
        chk("seed0 no late gnt", gnt, 2'b00);
        req = 2'b01;
        push_exp(2'b01);
        get_grant("after seed0");
        chk("after seed0 const", rnd, 8'h1C);
        req = 2'b00;

        // Non-zero seed in IDLE
        seed_ld = 1'b1;
        seed = 8'hA5;
        tick();
        seed_ld = 1'b0;
        m_sr = 8'hA5;
        req = 2'b01;
        push_exp(2'b01);
        get_grant("seed A5");
        req = 2'b00;

        // Reset asserted across the GRANT cycle edge
        do_reset();
        req = 2'b01;
        wait_gnt(n);
        chk("pre-reset grant seen", gnt, 2'b01);
        ar = 1'b0;
        tick();
        chk("grant reset gnt", gnt, 2'b00);
        chk("grant reset rnd", rnd, 8'h00);
        chk("grant reset busy", busy, 1'b0);
        tick();
        chk("grant reset held gnt", gnt, 2'b00);
        ar = 1'b1;
        req = 2'b00;
        tick();
        chk("post reset gnt", gnt, 2'b00);
        chk("post reset busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 SHALL have parameter STEPS, default 8: LFSR shifts per delivered byte, legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port ar  input  1  reset, synchronous, active-low: sampled only on the rising edge of clk; ar=0 resets.
REQ-004 SHALL have port req  input  2  per-requester random-byte request, level, held until grant.
REQ-005 SHALL have port seed_ld  input  1  one-cycle pulse: load seed into the LFSR.
REQ-006 SHALL have port seed  input  8  seed value, valid with seed_ld.
REQ-007 SHALL have port gnt  output  2  one-hot grant, one-cycle pulse, registered.
REQ-008 SHALL have port rnd  output  8  delivered random byte, registered, valid with gnt and held afterwards.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL own an internal 8-bit LFSR sr using x^8+x^6+x^5+x^4+1: shift = {sr[6:0], sr[7]^sr[5]^sr[4]^sr[3]}.
REQ-011 SHALL implement the FSM states IDLE, STEP and GRANT.
REQ-012 IDLE: sr holds; if req!=0, pick owner round-robin, load step counter with STEPS, go STEP; else stay.
REQ-013 Round-robin: if both req bits are set, grant the requester not granted last; if one bit is set, grant that requester.
REQ-014 The last-granted pointer SHALL reset to 1, so req[0] wins the first tie after reset.
REQ-015 STEP: each edge with req[owner]=1 shifts sr once and decrements the counter; the edge doing the final shift goes to GRANT and loads rnd with the post-shift sr.
REQ-016 STEP abort: if req[owner]=0 at an edge, no shift is performed, go IDLE, no gnt, rnd unchanged.
REQ-017 GRANT: gnt[owner]=1 for exactly this one cycle; update the last-granted pointer to owner; go IDLE unconditionally.
REQ-018 Latency: gnt SHALL be high in the cycle STEPS+1 clocks after the edge that samples req in IDLE.
REQ-019 With req held continuously, one IDLE cycle SHALL separate consecutive grants (period STEPS+2 cycles).
REQ-020 seed_ld=1 SHALL take priority in any state: sr<=seed (0x01 if seed==0x00), FSM<=IDLE, pending request dropped without gnt.
REQ-021 sr SHALL never become 0x00.
REQ-022 gnt SHALL be 0 outside GRANT; at most one gnt bit SHALL be high in any cycle.
REQ-023 rnd SHALL change only on the transition into GRANT.

Reset
REQ-024 ar=0 at an edge SHALL set sr=0x01, FSM=IDLE, gnt=2'b00, rnd=0x00, busy=0, last-granted=1, counter=0.
REQ-025 Reset SHALL override seed_ld and req; reset mid-STEP or mid-GRANT SHALL abort with no gnt pulse.

Verification
REQ-026 Reset, then req=2'b01 held, STEPS=8 -> gnt=2'b01 for 1 cycle, 9 cycles after sampling; rnd=0x1C.
REQ-027 Continue holding req=2'b01 -> next gnt=2'b01 10 cycles after the previous one; rnd=0x4B.
REQ-028 Reset, then req=2'b11 held -> grants alternate 01,10,01 every 10 cycles; rnd sequence 0x1C, 0x4B, ...
REQ-029 req[0] dropped after 3 STEP cycles -> busy falls next cycle, no gnt, rnd stays 0x00; next request continues from sr=0x08.
REQ-030 seed_ld with seed=0x00 during STEP -> no gnt, FSM IDLE, sr=0x01; following request yields rnd=0x1C.
REQ-031 ar=0 asserted during GRANT cycle edge -> all outputs at reset values next cycle, no further gnt.
